// File: rtl/r2fft_ostream.sv
// rtl/r2fft_ostream.sv - FFT result readout: DMA sweep of the result RAM onto a valid/ready stream.
// Optional half-spectrum readout selected by R2FFT_OSTREAM_HALF_EN.
module r2fft_ostream #(
    parameter int FFT_LENGTH = 1024,
    parameter int FFT_DW     = 16,
    localparam int FFT_N     = $clog2(FFT_LENGTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fft_done,
    input  logic [7:0]        fft_bfpexp,
    output logic              fin,
    output logic              dmaact,
    output logic [FFT_N-1:0]  dmaa,
    input  logic [FFT_DW-1:0] dmadr_real,
    input  logic [FFT_DW-1:0] dmadr_imag,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [FFT_DW-1:0] m_real,
    output logic [FFT_DW-1:0] m_imag,
    output logic [FFT_N-1:0]  m_index,
    output logic              m_last,
    output logic [7:0]        m_bfpexp,
    output logic              busy
);

`ifdef R2FFT_OSTREAM_HALF_EN
    localparam int LAST_BIN_I = FFT_LENGTH / 2 - 1;
`else
    localparam int LAST_BIN_I = FFT_LENGTH - 1;
`endif
    localparam logic [FFT_N-1:0] LAST_BIN = FFT_N'(LAST_BIN_I);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, FIN, WAIT_CLR} state_t;

    state_t             state, state_nx;
    logic [FFT_N-1:0]   rd_addr;
    logic               inflight;
    logic [FFT_N-1:0]   inflight_idx;
    logic               sk_valid;
    logic [FFT_DW-1:0]  sk_real, sk_imag;
    logic [FFT_N-1:0]   sk_index;
    logic               pop;
    logic [2:0]         pending;
    logic               issue_ok;

    // m_* registers are the FIFO head, the skid registers are the second entry.
    assign pop      = m_valid && m_ready;
    assign pending  = 3'(m_valid) + 3'(sk_valid) + 3'(inflight);
    assign issue_ok = pending < (3'd2 + 3'(pop));
    assign dmaa     = rd_addr;
    assign fin      = (state == FIN);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx = state;
        dmaact   = 1'b0;
        case (state)
            IDLE:     if (fft_done) state_nx = READ;
            READ: begin
                if (issue_ok) begin
                    dmaact = 1'b1;
                    if (rd_addr == LAST_BIN) state_nx = DRAIN;
                end
            end
            DRAIN:    if (!m_valid && !sk_valid && !inflight) state_nx = FIN;
            FIN:      state_nx = WAIT_CLR;
            WAIT_CLR: if (!fft_done) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rd_addr      <= '0;
            m_bfpexp     <= '0;
            inflight     <= 1'b0;
            inflight_idx <= '0;
        end else begin
            state        <= state_nx;
            inflight     <= dmaact;
            inflight_idx <= rd_addr;
            if (state == IDLE && fft_done) begin
                rd_addr  <= '0;
                m_bfpexp <= fft_bfpexp;
            end else if (dmaact) begin
                rd_addr  <= rd_addr + 1'b1;
            end
        end
    end

    // Read data lands one cycle after issue; the issue rule guarantees a free slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid  <= 1'b0;
            m_real   <= '0;
            m_imag   <= '0;
            m_index  <= '0;
            m_last   <= 1'b0;
            sk_valid <= 1'b0;
            sk_real  <= '0;
            sk_imag  <= '0;
            sk_index <= '0;
        end else if (pop && sk_valid) begin
            m_real   <= sk_real;
            m_imag   <= sk_imag;
            m_index  <= sk_index;
            m_last   <= (sk_index == LAST_BIN);
            sk_valid <= inflight;
            if (inflight) begin
                sk_real  <= dmadr_real;
                sk_imag  <= dmadr_imag;
                sk_index <= inflight_idx;
            end
        end else if (pop || !m_valid) begin
            m_valid <= inflight;
            if (inflight) begin
                m_real  <= dmadr_real;
                m_imag  <= dmadr_imag;
                m_index <= inflight_idx;
                m_last  <= (inflight_idx == LAST_BIN);
            end
        end else if (inflight) begin
            sk_valid <= 1'b1;
            sk_real  <= dmadr_real;
            sk_imag  <= dmadr_imag;
            sk_index <= inflight_idx;
        end
    end

endmodule

// File: tb/tb_r2fft_ostream.sv
// tb/tb_r2fft_ostream.sv - self-checking bench for r2fft_ostream with a RAM model and frame scoreboard.
module tb_r2fft_ostream;

    localparam int L  = 16;
    localparam int DW = 16;
`ifdef R2FFT_OSTREAM_HALF_EN
    localparam int NB = L / 2;
`else
    localparam int NB = L;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          fft_done;
    logic [7:0]    fft_bfpexp;
    logic          fin, dmaact, m_valid, m_ready, m_last, busy;
    logic [3:0]    dmaa, m_index;
    logic [DW-1:0] dmadr_real, dmadr_imag, m_real, m_imag;
    logic [7:0]    m_bfpexp;

    logic [DW-1:0] mem_r [L];
    logic [DW-1:0] mem_i [L];

    int checks = 0;
    int failures = 0;

    r2fft_ostream #(.FFT_LENGTH(L), .FFT_DW(DW)) dut (
        .clk(clk), .rst(rst), .fft_done(fft_done), .fft_bfpexp(fft_bfpexp),
        .fin(fin), .dmaact(dmaact), .dmaa(dmaa),
        .dmadr_real(dmadr_real), .dmadr_imag(dmadr_imag),
        .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
        .m_index(m_index), .m_last(m_last), .m_bfpexp(m_bfpexp), .busy(busy)
    );

    always #5 clk = ~clk;

    // Result RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (dmaact) begin
            dmadr_real <= mem_r[dmaa];
            dmadr_imag <= mem_i[dmaa];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_fin"}, 32'(fin), 0);
        chk({pfx, "_dmaact"}, 32'(dmaact), 0);
        chk({pfx, "_m_valid"}, 32'(m_valid), 0);
        chk({pfx, "_m_last"}, 32'(m_last), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_dmaa"}, 32'(dmaa), 0);
        chk({pfx, "_m_index"}, 32'(m_index), 0);
        chk({pfx, "_m_real"}, 32'(m_real), 0);
        chk({pfx, "_m_imag"}, 32'(m_imag), 0);
        chk({pfx, "_m_bfpexp"}, 32'(m_bfpexp), 0);
    endtask

    // mode: 0 ready high, 1 ready toggling, 2 20-cycle stall mid-frame, 3 random ready.
    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic run_frame(input int mode, input int exp0, input int exp1,
                             input bit drop_mid, input bit timing);
        logic [7:0]    e0, e1;
        logic [DW-1:0] h_r, h_i;
        logic [3:0]    h_idx;
        bit            hold, done;
        int            exp_rd, acc, fin_cnt, stall, first_dma, first_pop, last_acc, fin_cyc;
        e0 = exp0[7:0];
        e1 = exp1[7:0];
        for (int i = 0; i < L; i++) begin
            mem_r[i] = DW'($urandom);
            mem_i[i] = DW'($urandom);
        end
        exp_rd = 0; acc = 0; fin_cnt = 0; stall = 0;
        first_dma = -1; first_pop = -1; last_acc = -1; fin_cyc = -1;
        hold = 1'b0; done = 1'b0;
        fft_bfpexp = e0;
        fft_done = 1'b1;
        for (int n = 0; n < 400 && !done; n++) begin
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = (n % 2 == 0);
                2: begin
                    if (acc >= 5 && stall < 20) begin
                        m_ready = 1'b0;
                        stall++;
                    end else m_ready = 1'b1;
                end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (acc >= NB / 2) fft_bfpexp = e1;
            if (drop_mid && acc >= 4) fft_done = 1'b0;
            #1;
            if (hold) begin
                chk("hold_valid", 32'(m_valid), 1);
                chk("hold_real", 32'(m_real), 32'(h_r));
                chk("hold_imag", 32'(m_imag), 32'(h_i));
                chk("hold_index", 32'(m_index), 32'(h_idx));
            end
            if (dmaact) begin
                if (first_dma < 0) begin
                    first_dma = n;
                    if (timing) chk("first_dmaact_latency", 32'(n), 1);
                end
                if (timing) chk("dmaact_consecutive", 32'(n), 32'(first_dma + exp_rd));
                chk("dmaa", 32'(dmaa), 32'(exp_rd));
                exp_rd++;
            end
            if (m_valid && m_ready) begin
                if (first_pop < 0) first_pop = n;
                if (timing) chk("m_valid_no_bubble", 32'(n), 32'(first_pop + acc));
                if (acc < NB) begin
                    chk("m_index", 32'(m_index), 32'(acc));
                    chk("m_real", 32'(m_real), 32'(mem_r[acc]));
                    chk("m_imag", 32'(m_imag), 32'(mem_i[acc]));
                    chk("m_last", 32'(m_last), 32'(acc == NB - 1));
                    chk("m_bfpexp", 32'(m_bfpexp), 32'(e0));
                end else chk("extra_sample", 32'(acc), 32'(NB - 1));
                acc++;
                last_acc = n;
            end
            chk("outstanding_le2", 32'(exp_rd - acc <= 2), 1);
            if (fin) begin
                fin_cnt++;
                fin_cyc = n;
                done = 1'b1;
                chk("fin_after_all_bins", 32'(acc), 32'(NB));
            end
            hold = m_valid && !m_ready;
            h_r = m_real;
            h_i = m_imag;
            h_idx = m_index;
            @(negedge clk);
        end
        chk("bins_accepted", 32'(acc), 32'(NB));
        chk("reads_issued", 32'(exp_rd), 32'(NB));
        chk("fin_seen", 32'(fin_cnt), 1);
        // Last accept edge closes cycle last_acc; fin rises one clock after that edge.
        if (timing) chk("fin_latency", 32'(fin_cyc - last_acc), 2);
        m_ready = 1'b1;
        if (!drop_mid) begin
            for (int k = 0; k < 3; k++) begin
                #1;
                chk("wait_clr_no_dmaact", 32'(dmaact), 0);
                chk("wait_clr_no_fin", 32'(fin), 0);
                chk("wait_clr_busy", 32'(busy), 1);
                @(negedge clk);
            end
        end
        fft_done = 1'b0;
        @(negedge clk);
        #1;
        chk("back_to_idle", 32'(busy), 0);
        chk("idle_no_dmaact", 32'(dmaact), 0);
        @(negedge clk);
    endtask

    initial begin
        bit found;
        rst = 1'b0;
        fft_done = 1'b0;
        fft_bfpexp = 8'h00;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_after_reset_busy", 32'(busy), 0);
        @(negedge clk);

        run_frame(0, -3, 5, 1'b0, 1'b1);
        run_frame(1, -3, 5, 1'b0, 1'b0);
        run_frame(2, 12, -7, 1'b0, 1'b0);
        run_frame(3, 1, 2, 1'b1, 1'b0);

        // Reset while the sweep is at bin 7, fft_done kept high.
        for (int i = 0; i < L; i++) begin
            mem_r[i] = DW'($urandom);
            mem_i[i] = DW'($urandom);
        end
        fft_done = 1'b1;
        m_ready = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            #1;
            if (m_valid && m_index == 4'd7) found = 1'b1;
        end
        chk("reached_bin7", 32'(found), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero("midreset");
        @(negedge clk);
        #1;
        check_zero("midreset_hold");
        @(negedge clk);
        rst = 1'b1;
        run_frame(0, 7, 2, 1'b0, 1'b1);

        run_frame(3, -100, 100, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
